sha_loader: RTL
===============

# sha_loader

Byte-stream front end for the `sha` top level. It accepts message bytes over a valid/ready handshake and assembles them into the `Data[0:Nl-1]` array consumed by `sha`. It pulses `Enable`, holds `Data` stable while the hash runs, captures `Hash` on `sha`'s `Ready` pulse, and presents the digest on an output valid/ready handshake. It sits directly upstream of `sha` and also closes the loop on its result.

## Interface
- `Nl`, default from `sha_const`: message length in bytes; must be ≥ 1.
- `Nk`, default from `sha_const`: digest width in bits; equals the `sha` `Hash` width.
- `rst`  in  1  asynchronous, active-low reset.
- `clk`  in  1  clock; all state updates on its rising edge.
- `In_Data`  in  8  message byte.
- `In_Valid`  in  1  `In_Data` is valid.
- `In_Ready`  out  1  loader accepts a byte this cycle.
- `Data`  out  8 × [0:Nl-1]  assembled message to `sha.Data`. Byte 0 is the first byte accepted.
- `Enable`  out  1  single-cycle start pulse to `sha.Enable`.
- `Hash`  in  Nk  digest from `sha.Hash`.
- `Ready`  in  1  `sha.Ready`; a one-cycle pulse qualifying `Hash`.
- `Digest`  out  Nk  captured digest.
- `Out_Valid`  out  1  `Digest` is valid.
- `Out_Ready`  in  1  consumer takes `Digest`.

## Operation
- States: FILL, START, WAIT, OUT. Reset state is FILL.
- Byte counter `cnt`:
  - Width `$clog2(Nl+1)`; reset value 0.
  - Counts accepted bytes. It never exceeds `Nl-1` before wrapping to 0.
- FILL:
  - `In_Ready`=1.
  - On `In_Valid & In_Ready`: `Data[cnt]` ← `In_Data` and `cnt`++.
  - When the accepted byte is at `cnt==Nl-1`: `cnt` ← 0 and go to START.
- START:
  - `Enable`=1 for exactly this one cycle.
  - `In_Ready`=0.
  - Go to WAIT unconditionally.
- WAIT:
  - `In_Ready`=0 and `Data` is frozen.
  - On `Ready==1`: `Digest` ← `Hash` and go to OUT.
- OUT:
  - `Out_Valid`=1 and `Digest` is held.
  - On `Out_Ready==1`: go to FILL.
  - `Digest` keeps its value until the next capture.
- `Ready` outside WAIT is ignored.
- `Out_Ready` while `Out_Valid`=0 is ignored.
- `In_Valid` outside FILL is ignored; no byte is dropped silently, because `In_Ready`=0 there.
- `Data` bytes not yet written in the current message hold the previous message's values. `sha` only sees `Data` after all `Nl` bytes are written.
- `Enable`, `Out_Valid` and `In_Ready` are decoded from the registered state only. There is no combinational path from `In_Valid`, `Ready` or `Out_Ready` to any output.

## Timing
- Reset (`rst`=0, asynchronous):
  - State ← FILL, `cnt` ← 0.
  - `Data` all bytes ← 0, `Digest` ← 0.
  - `Enable`=0, `Out_Valid`=0.
  - `In_Ready`=0 while `rst`=0, and 1 from the first cycle after deassertion.
- Reset mid-operation in any state aborts the message and discards the digest. `sha` is reset by the same `rst`.
- Last-byte acceptance at edge k:
  - `Enable`=1 during cycle k..k+1.
  - WAIT from edge k+1.
- `Ready` sampled high at edge m: `Out_Valid`=1 from edge m.
- `Out_Ready` high at edge n:
  - `Out_Valid`=0 and `In_Ready`=1 from edge n.
  - The first byte of the next message can be accepted at edge n+1.
- Fill rate: one byte per cycle when `In_Valid` is held high.
- `Out_Valid` stays high until accepted, even for unbounded stall.

## Configuration
- Macro: `SHA_LOADER_CLEAR_EN`.
- Defined:
  - On the WAIT→OUT transition (the `Ready` capture edge), all `Data` bytes are cleared to 0 in the same edge. No message bytes remain resident after hashing.
- Undefined:
  - `Data` retains the last message until overwritten by new bytes or reset.
- Digest behaviour is identical in both configurations.

## Test plan
- Nk=256, Nl=3: stream 0x61,0x62,0x63 with `In_Valid` held high, `Out_Ready`=1.
  - One `Enable` pulse one cycle after the third byte.
  - `Digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad with `Out_Valid` for one cycle.
- Same message with `In_Valid` toggled every other cycle and `Out_Ready`=0 for 20 cycles.
  - Same digest.
  - `Out_Valid` held 21 cycles.
  - `In_Ready`=0 throughout WAIT/OUT.
- `In_Valid` held high through WAIT, with the bytes of a second message queued.
  - No bytes accepted until OUT is acknowledged.
  - Second digest is correct for the second message.
- Spurious `Ready` pulse injected in FILL after one byte.
  - `Digest` and `Out_Valid` unchanged.
  - `cnt`=1 is preserved.
- Assert `rst`=0 asynchronously mid-WAIT.
  - Immediately: `Data`=0, `Digest`=0, `Out_Valid`=0, `Enable`=0.
  - After release: a fresh "abc" message yields the correct digest.
- Two back-to-back messages, with and without `SHA_LOADER_CLEAR_EN`.
  - Defined: `Data`=0 after the capture edge.
  - Undefined: `Data` retains 0x61,0x62,0x63 after the capture edge.

Source files
------------

// File: rtl/sha_loader_if.sv
// rtl/sha_loader_if.sv - byte-in, sha-side and digest-out signal bundle for sha_loader
interface sha_loader_if #(
  parameter int Nl = 3,
  parameter int Nk = 256
);
  logic [7:0]    In_Data;
  logic          In_Valid;
  logic          In_Ready;
  logic [7:0]    Data [0:Nl-1];
  logic          Enable;
  logic [Nk-1:0] Hash;
  logic          Ready;
  logic [Nk-1:0] Digest;
  logic          Out_Valid;
  logic          Out_Ready;

  modport slave (
    input  In_Data, In_Valid, Hash, Ready, Out_Ready,
    output In_Ready, Data, Enable, Digest, Out_Valid
  );

  modport master (
    output In_Data, In_Valid, Hash, Ready, Out_Ready,
    input  In_Ready, Data, Enable, Digest, Out_Valid
  );
endinterface

// File: rtl/sha_loader.sv
// rtl/sha_loader.sv - assembles Nl message bytes for sha, starts it, returns the digest (option: SHA_LOADER_CLEAR_EN)
module sha_loader #(
  parameter int Nl = 3,
  parameter int Nk = 256
) (
  input logic         clk,
  input logic         rst,
  sha_loader_if.slave bus
);
  localparam int CW = $clog2(Nl + 1);
  localparam logic [CW-1:0] LAST = CW'(Nl - 1);

  typedef enum logic [1:0] {FILL, START, WAIT, OUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    data [0:Nl-1];
  logic [Nk-1:0] digest;
  logic          fill_s, enable_s, out_valid_s;
  logic          accept, capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fill_s      = 1'b0;
    enable_s    = 1'b0;
    out_valid_s = 1'b0;
    case (state)
      FILL: begin
        fill_s = 1'b1;
        if (bus.In_Valid && cnt == LAST) state_nxt = START;
      end
      START: begin
        enable_s  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.Ready) state_nxt = OUT;
      end
      OUT: begin
        out_valid_s = 1'b1;
        if (bus.Out_Ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // In_Ready is held low for the whole reset interval, not just until the first clock
  assign bus.In_Ready  = fill_s & rst;
  assign bus.Enable    = enable_s;
  assign bus.Out_Valid = out_valid_s;
  assign bus.Digest    = digest;
  assign bus.Data      = data;

  assign accept  = fill_s & bus.In_Valid;
  assign capture = (state == WAIT) & bus.Ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Nl; i++) data[i] <= '0;
    end else if (accept) begin
      data[cnt] <= bus.In_Data;
`ifdef SHA_LOADER_CLEAR_EN
    end else if (capture) begin
      // scrub the message once sha has consumed it
      for (int i = 0; i < Nl; i++) data[i] <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         digest <= '0;
    else if (capture) digest <= bus.Hash;
  end
endmodule
